// File: rtl/link_training_ctrl_if.sv
// Training handshake bundle between the link controller and the TX preamble
// generator / RX detector pair.
interface link_training_ctrl_if #(
    parameter int unsigned DIV_WIDTH = 8
);
    logic                 tx_start;
    logic                 tx_done;
    logic                 rx_start;
    logic                 rx_enable;
    logic                 rx_done;
    logic [DIV_WIDTH-1:0] rx_clk_div;

    // Controller side.
    modport master (
        output tx_start,
        output rx_start,
        output rx_enable,
        input  tx_done,
        input  rx_done,
        input  rx_clk_div
    );

    // Training-block side.
    modport slave (
        input  tx_start,
        input  rx_start,
        input  rx_enable,
        output tx_done,
        output rx_done,
        output rx_clk_div
    );
endinterface

// File: rtl/link_training_ctrl.sv
// Link bring-up sequencer: preamble TX, then RX divider detection, divider
// validation with bounded retries, then divider lock and link_up.
module link_training_ctrl #(
    parameter int unsigned  DIV_WIDTH   = 8,
    parameter int unsigned  TO_WIDTH    = 16,
    parameter int unsigned  MAX_RETRIES = 3,
    parameter int unsigned  DIV_MIN     = 2,
    localparam int unsigned RW          = $clog2(MAX_RETRIES + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  link_req_i,
    input  logic [TO_WIDTH-1:0]   timeout_cycles_i,
    link_training_ctrl_if.master  trn,
    output logic [DIV_WIDTH-1:0]  clk_div_locked_o,
    output logic                  link_up_o,
    output logic                  link_fail_o,
    output logic                  busy_o,
    output logic [RW-1:0]         retry_cnt_o
);

    typedef enum logic [3:0] {
        StIdle,
        StTxStart,
        StTxWait,
        StRxStart,
        StRxWait,
        StCapture,
        StCheck,
        StRetry,
        StLinked,
        StFailed
    } state_e;

    state_e               state_q, state_d;
    logic [TO_WIDTH-1:0]  cnt_q, cnt_d;
    logic [RW-1:0]        retry_q, retry_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DIV_WIDTH-1:0] locked_q, locked_d;
    logic                 timed_out;
    logic [TO_WIDTH-1:0]  cnt_inc;

    // Timeout is checked on the pre-increment value; zero disables it.
    assign timed_out = (timeout_cycles_i != '0) && (cnt_q == timeout_cycles_i);
    // Saturating increment so a disabled timeout never wraps into a false hit.
    assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + TO_WIDTH'(1);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            retry_q  <= '0;
            div_q    <= '0;
            locked_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            div_q    <= div_d;
            locked_q <= locked_d;
        end
    end

    // Next-state and datapath update; done pulses win over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        retry_d  = retry_q;
        div_d    = div_q;
        locked_d = locked_q;
        if (state_q != StIdle && !link_req_i) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle: begin
                    if (link_req_i) begin
                        state_d = StTxStart;
                        retry_d = '0;
                    end
                end
                StTxStart: begin
                    state_d = StTxWait;
                    cnt_d   = '0;
                end
                StTxWait: begin
                    if (trn.tx_done)    state_d = StRxStart;
                    else if (timed_out) state_d = StRetry;
                    else                cnt_d   = cnt_inc;
                end
                StRxStart: begin
                    state_d = StRxWait;
                    cnt_d   = '0;
                end
                StRxWait: begin
                    if (trn.rx_done)    state_d = StCapture;
                    else if (timed_out) state_d = StRetry;
                    else                cnt_d   = cnt_inc;
                end
                StCapture: begin
                    div_d   = trn.rx_clk_div;
                    state_d = StCheck;
                end
                StCheck: begin
                    if (div_q >= DIV_WIDTH'(DIV_MIN)) begin
                        locked_d = div_q;
                        state_d  = StLinked;
                    end else begin
                        state_d  = StRetry;
                    end
                end
                StRetry: begin
                    retry_d = retry_q + RW'(1);
                    state_d = (retry_d == RW'(MAX_RETRIES)) ? StFailed : StTxStart;
                end
                StLinked: state_d = StLinked;
                StFailed: state_d = StFailed;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        trn.tx_start  = (state_q == StTxStart);
        trn.rx_start  = (state_q == StRxStart);
        trn.rx_enable = (state_q == StRxStart) || (state_q == StRxWait);
        link_up_o     = (state_q == StLinked);
        link_fail_o   = (state_q == StFailed);
        busy_o        = !((state_q == StIdle) || (state_q == StLinked) ||
                          (state_q == StFailed));
    end

    assign clk_div_locked_o = locked_q;
    assign retry_cnt_o      = retry_q;

endmodule

// File: tb/tb_link_training_ctrl.sv
// Directed bench for link_training_ctrl.
module tb_link_training_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        link_req;
    logic [15:0] timeout_cycles;
    logic [7:0]  clk_div_locked;
    logic        link_up;
    logic        link_fail;
    logic        busy;
    logic [1:0]  retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    link_training_ctrl_if #(.DIV_WIDTH(8)) trn_if ();

    link_training_ctrl #(
        .DIV_WIDTH  (8),
        .TO_WIDTH   (16),
        .MAX_RETRIES(3),
        .DIV_MIN    (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .link_req_i      (link_req),
        .timeout_cycles_i(timeout_cycles),
        .trn             (trn_if),
        .clk_div_locked_o(clk_div_locked),
        .link_up_o       (link_up),
        .link_fail_o     (link_fail),
        .busy_o          (busy),
        .retry_cnt_o     (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full successful handshake starting in the TX_START cycle, ending after CHECK.
    task automatic attempt(input logic [7:0] div);
        tick();                          // TX_WAIT
        tick();
        tick();
        trn_if.tx_done = 1'b1;
        tick();                          // RX_START
        trn_if.tx_done = 1'b0;
        tick();                          // RX_WAIT
        tick();
        trn_if.rx_done = 1'b1;
        tick();                          // CAPTURE
        trn_if.rx_done    = 1'b0;
        trn_if.rx_clk_div = div;
        tick();                          // CHECK
        tick();                          // LINKED or RETRY
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if ({link_up, link_fail, busy, trn_if.tx_start, trn_if.rx_start, trn_if.rx_enable}
            !== 6'b0) begin
            $display("FAIL reset_flags: got %b expected 000000",
                     {link_up, link_fail, busy, trn_if.tx_start, trn_if.rx_start,
                      trn_if.rx_enable});
            n_fail++;
        end
        n_checks++;
        if (clk_div_locked !== 8'd0 || retry_cnt !== 2'd0) begin
            $display("FAIL reset_regs: got div=%0d retry=%0d expected 0/0",
                     clk_div_locked, retry_cnt);
            n_fail++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (trn_if.tx_start !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_release_idle: got tx_start=%b busy=%b expected 0/0",
                     trn_if.tx_start, busy);
            n_fail++;
        end
    endtask

    task automatic test_nominal();
        timeout_cycles = 16'd0;
        link_req       = 1'b1;
        tick();                          // TX_START
        n_checks++;
        if (trn_if.tx_start !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL nom_tx_start: got tx_start=%b busy=%b expected 1/1",
                     trn_if.tx_start, busy);
            n_fail++;
        end
        tick();                          // TX_WAIT, cycle 1 after tx_start
        n_checks++;
        if (trn_if.tx_start !== 1'b0) begin
            $display("FAIL nom_tx_pulse_width: got %b expected 0", trn_if.tx_start);
            n_fail++;
        end
        repeat (19) tick();              // cycle 20 after tx_start
        trn_if.tx_done = 1'b1;
        tick();
        trn_if.tx_done = 1'b0;
        n_checks++;
        if (trn_if.rx_start !== 1'b1 || trn_if.rx_enable !== 1'b1 || trn_if.tx_start !== 1'b0)
        begin
            $display("FAIL nom_rx_start: got rx_start=%b rx_enable=%b tx_start=%b expected 1/1/0",
                     trn_if.rx_start, trn_if.rx_enable, trn_if.tx_start);
            n_fail++;
        end
        repeat (20) tick();
        n_checks++;
        if (trn_if.rx_enable !== 1'b1 || trn_if.rx_start !== 1'b0) begin
            $display("FAIL nom_rx_wait: got rx_enable=%b rx_start=%b expected 1/0",
                     trn_if.rx_enable, trn_if.rx_start);
            n_fail++;
        end
        repeat (20) tick();              // cycle 40 after rx_start
        trn_if.rx_done = 1'b1;
        tick();
        trn_if.rx_done    = 1'b0;
        trn_if.rx_clk_div = 8'd10;
        tick();
        n_checks++;
        if (link_up !== 1'b0) begin
            $display("FAIL nom_link_up_early: got %b expected 0", link_up);
            n_fail++;
        end
        tick();                          // 3 cycles after rx_done
        n_checks++;
        if (link_up !== 1'b1 || busy !== 1'b0 || clk_div_locked !== 8'd10 || retry_cnt !== 2'd0)
        begin
            $display("FAIL nom_linked: got up=%b busy=%b div=%0d retry=%0d expected 1/0/10/0",
                     link_up, busy, clk_div_locked, retry_cnt);
            n_fail++;
        end
        trn_if.rx_clk_div = 8'd99;
        repeat (3) tick();
        n_checks++;
        if (clk_div_locked !== 8'd10 || link_up !== 1'b1) begin
            $display("FAIL nom_hold: got div=%0d up=%b expected 10/1", clk_div_locked, link_up);
            n_fail++;
        end
        link_req = 1'b0;
        tick();
        n_checks++;
        if (link_up !== 1'b0 || clk_div_locked !== 8'd10) begin
            $display("FAIL nom_drop: got up=%b div=%0d expected 0/10", link_up, clk_div_locked);
            n_fail++;
        end
    endtask

    task automatic test_bad_divider();
        timeout_cycles = 16'd0;
        link_req       = 1'b1;
        tick();                          // TX_START
        attempt(8'd1);                   // -> RETRY
        n_checks++;
        if (busy !== 1'b1 || link_up !== 1'b0 || retry_cnt !== 2'd0) begin
            $display("FAIL bad_retry_state: got busy=%b up=%b retry=%0d expected 1/0/0",
                     busy, link_up, retry_cnt);
            n_fail++;
        end
        tick();                          // TX_START
        n_checks++;
        if (trn_if.tx_start !== 1'b1 || retry_cnt !== 2'd1) begin
            $display("FAIL bad_retry1: got tx_start=%b retry=%0d expected 1/1",
                     trn_if.tx_start, retry_cnt);
            n_fail++;
        end
        attempt(8'd1);
        tick();
        n_checks++;
        if (trn_if.tx_start !== 1'b1 || retry_cnt !== 2'd2) begin
            $display("FAIL bad_retry2: got tx_start=%b retry=%0d expected 1/2",
                     trn_if.tx_start, retry_cnt);
            n_fail++;
        end
        attempt(8'd12);
        n_checks++;
        if (link_up !== 1'b1 || clk_div_locked !== 8'd12 || retry_cnt !== 2'd2) begin
            $display("FAIL bad_linked: got up=%b div=%0d retry=%0d expected 1/12/2",
                     link_up, clk_div_locked, retry_cnt);
            n_fail++;
        end
        link_req = 1'b0;
        tick();
        n_checks++;
        if (retry_cnt !== 2'd2 || link_up !== 1'b0) begin
            $display("FAIL bad_idle_retry_kept: got retry=%0d up=%b expected 2/0",
                     retry_cnt, link_up);
            n_fail++;
        end
    endtask

    task automatic test_timeout();
        int cyc;
        int n_pulses;
        int pulse_at[4];
        int fail_at;
        timeout_cycles = 16'd50;
        link_req       = 1'b1;
        cyc            = 0;
        n_pulses       = 0;
        fail_at        = -1;
        for (int i = 0; i < 400 && fail_at < 0; i++) begin
            tick();
            cyc++;
            if (trn_if.tx_start === 1'b1 && n_pulses < 4) begin
                pulse_at[n_pulses] = cyc;
                n_pulses++;
            end
            if (link_fail === 1'b1) fail_at = cyc;
        end
        n_checks++;
        if (n_pulses !== 3) begin
            $display("FAIL to_pulse_count: got %0d expected 3", n_pulses);
            n_fail++;
        end
        if (n_pulses >= 3) begin
            // 52 idle cycles between pulses: TX_WAIT counts 0..50, then RETRY.
            n_checks++;
            if (pulse_at[1] - pulse_at[0] !== 53 || pulse_at[2] - pulse_at[1] !== 53) begin
                $display("FAIL to_pulse_gap: got %0d,%0d expected 53,53",
                         pulse_at[1] - pulse_at[0], pulse_at[2] - pulse_at[1]);
                n_fail++;
            end
            n_checks++;
            if (fail_at - pulse_at[2] !== 53) begin
                $display("FAIL to_fail_time: got %0d expected 53", fail_at - pulse_at[2]);
                n_fail++;
            end
        end
        n_checks++;
        if (link_fail !== 1'b1 || retry_cnt !== 2'd3 || busy !== 1'b0 || link_up !== 1'b0) begin
            $display("FAIL to_failed: got fail=%b retry=%0d busy=%b up=%b expected 1/3/0/0",
                     link_fail, retry_cnt, busy, link_up);
            n_fail++;
        end
        link_req = 1'b0;
        tick();
        n_checks++;
        if (link_fail !== 1'b0) begin
            $display("FAIL to_drop: got fail=%b expected 0", link_fail);
            n_fail++;
        end
    endtask

    task automatic test_abort();
        timeout_cycles = 16'd0;
        link_req       = 1'b1;
        tick();                          // TX_START
        attempt(8'd0);                   // below DIV_MIN -> RETRY
        tick();                          // TX_START, retry=1
        tick();
        trn_if.tx_done = 1'b1;
        tick();                          // RX_START
        trn_if.tx_done = 1'b0;
        repeat (5) tick();               // RX_WAIT
        n_checks++;
        if (trn_if.rx_enable !== 1'b1 || busy !== 1'b1 || retry_cnt !== 2'd1) begin
            $display("FAIL abort_pre: got rx_enable=%b busy=%b retry=%0d expected 1/1/1",
                     trn_if.rx_enable, busy, retry_cnt);
            n_fail++;
        end
        link_req       = 1'b0;
        trn_if.rx_done = 1'b1;
        tick();
        trn_if.rx_done = 1'b0;
        n_checks++;
        if (trn_if.rx_enable !== 1'b0 || busy !== 1'b0 || link_up !== 1'b0 ||
            clk_div_locked !== 8'd12) begin
            $display("FAIL abort_idle: got rx_enable=%b busy=%b up=%b div=%0d expected 0/0/0/12",
                     trn_if.rx_enable, busy, link_up, clk_div_locked);
            n_fail++;
        end
        repeat (4) tick();
        n_checks++;
        if (link_up !== 1'b0 || trn_if.tx_start !== 1'b0) begin
            $display("FAIL abort_stay: got up=%b tx_start=%b expected 0/0",
                     link_up, trn_if.tx_start);
            n_fail++;
        end
        link_req = 1'b1;
        tick();
        n_checks++;
        if (trn_if.tx_start !== 1'b1 || retry_cnt !== 2'd0) begin
            $display("FAIL abort_restart: got tx_start=%b retry=%0d expected 1/0",
                     trn_if.tx_start, retry_cnt);
            n_fail++;
        end
        attempt(8'd2);                   // DIV_MIN itself is accepted
        n_checks++;
        if (link_up !== 1'b1 || clk_div_locked !== 8'd2) begin
            $display("FAIL abort_div_min: got up=%b div=%0d expected 1/2", link_up, clk_div_locked);
            n_fail++;
        end
        link_req = 1'b0;
        tick();
    endtask

    task automatic test_race();
        timeout_cycles = 16'd10;
        link_req       = 1'b1;
        tick();                          // TX_START
        tick();                          // TX_WAIT cnt=0
        trn_if.rx_done = 1'b1;
        tick();                          // cnt=1
        trn_if.rx_done = 1'b0;
        n_checks++;
        if (trn_if.rx_start !== 1'b0 || trn_if.rx_enable !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL race_stray_rx: got rx_start=%b rx_enable=%b busy=%b expected 0/0/1",
                     trn_if.rx_start, trn_if.rx_enable, busy);
            n_fail++;
        end
        repeat (9) tick();               // cnt=10: timeout cycle
        trn_if.tx_done = 1'b1;
        tick();
        trn_if.tx_done = 1'b0;
        n_checks++;
        if (trn_if.rx_start !== 1'b1 || retry_cnt !== 2'd0) begin
            $display("FAIL race_tx_done_wins: got rx_start=%b retry=%0d expected 1/0",
                     trn_if.rx_start, retry_cnt);
            n_fail++;
        end
        tick();                          // RX_WAIT cnt=0
        trn_if.tx_done = 1'b1;
        tick();                          // cnt=1
        trn_if.tx_done = 1'b0;
        n_checks++;
        if (trn_if.rx_enable !== 1'b1 || trn_if.rx_start !== 1'b0) begin
            $display("FAIL race_stray_tx: got rx_enable=%b rx_start=%b expected 1/0",
                     trn_if.rx_enable, trn_if.rx_start);
            n_fail++;
        end
        repeat (9) tick();               // cnt=10: timeout cycle
        trn_if.rx_done = 1'b1;
        tick();                          // CAPTURE
        trn_if.rx_done    = 1'b0;
        trn_if.rx_clk_div = 8'd7;
        tick();
        tick();
        n_checks++;
        if (link_up !== 1'b1 || clk_div_locked !== 8'd7 || retry_cnt !== 2'd0) begin
            $display("FAIL race_rx_done_wins: got up=%b div=%0d retry=%0d expected 1/7/0",
                     link_up, clk_div_locked, retry_cnt);
            n_fail++;
        end
    endtask

    task automatic test_reset_linked();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({link_up, link_fail, busy, trn_if.tx_start, trn_if.rx_start, trn_if.rx_enable}
            !== 6'b0 || clk_div_locked !== 8'd0 || retry_cnt !== 2'd0) begin
            $display("FAIL async_reset: got flags=%b div=%0d retry=%0d expected 000000/0/0",
                     {link_up, link_fail, busy, trn_if.tx_start, trn_if.rx_start,
                      trn_if.rx_enable}, clk_div_locked, retry_cnt);
            n_fail++;
        end
        link_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (trn_if.tx_start !== 1'b0 || trn_if.rx_start !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL reset_no_pulse: got tx_start=%b rx_start=%b busy=%b expected 0/0/0",
                     trn_if.tx_start, trn_if.rx_start, busy);
            n_fail++;
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        link_req          = 1'b0;
        timeout_cycles    = 16'd0;
        trn_if.tx_done    = 1'b0;
        trn_if.rx_done    = 1'b0;
        trn_if.rx_clk_div = 8'd0;
        test_reset();
        test_nominal();
        test_bad_divider();
        test_timeout();
        test_abort();
        test_race();
        test_reset_linked();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
